// File: rtl/mem_write_checker.sv
// mem_write_checker: arms on a start pulse, then compares every processor
// store against an ordered table of expected (address, data) writes.
// It ends in PASS after all expected writes have been seen in order, in FAIL
// on the first unexpected store, or in TIMEOUT when the cycle budget runs out.
// Stores to the scratch address IGNORE_ADR that are not the next expected
// write are tolerated.
module mem_write_checker #(
  parameter int WIDTH          = 16,
  parameter int DEPTH          = 4,
  parameter int IGNORE_ADR     = 80,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1,
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [WIDTH-1:0] cfg_adr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] match_count,
  output logic [WIDTH-1:0] fail_adr,
  output logic [WIDTH-1:0] fail_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [WIDTH-1:0] IGN_ADR    = WIDTH'(IGNORE_ADR);

  // Expected-write table; holds its contents across reset so a check can be rerun.
  logic [WIDTH-1:0] exp_adr_q  [DEPTH];
  logic [WIDTH-1:0] exp_data_q [DEPTH];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [WIDTH-1:0] fail_adr_q, fail_adr_d;
  logic [WIDTH-1:0] fail_data_q, fail_data_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             busy_q, pass_q, fail_q, timeout_q;

  logic [IDX_W-1:0] ptr;
  logic             store;
  logic             hit;

  // The next expected entry is always the one indexed by the matches so far.
  assign ptr   = IDX_W'(match_q);
  // Only a clean 1 counts as a store; 0, X and Z are all treated as idle.
  assign store = (memwrite === 1'b1);
  assign hit   = (dataadr == exp_adr_q[ptr]) && (writedata == exp_data_q[ptr]);

  // Table writes are locked out while a check is in flight and during reset.
  always_ff @(posedge clk) begin
    if (!reset && cfg_we && (state_q != ARMED) && (int'(cfg_idx) < DEPTH)) begin
      exp_adr_q[cfg_idx]  <= cfg_adr;
      exp_data_q[cfg_idx] <= cfg_data;
    end
  end

  // Next-state decision: terminal events (pass/fail) outrank the timeout.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    match_d     = match_q;
    fail_adr_d  = fail_adr_q;
    fail_data_d = fail_data_q;
    timer_d     = timer_q;
    case (state_q)
      ARMED: begin
        timer_d = timer_q + TMR_W'(1);
        if (count_q == '0) begin
          state_d = PASS;
        end else if (store && hit) begin
          match_d = match_q + CNT_W'(1);
          if ((match_q + CNT_W'(1)) == count_q) begin
            state_d = PASS;
          end
        end else if (store && (dataadr != IGN_ADR)) begin
          state_d     = FAIL;
          fail_adr_d  = dataadr;
          fail_data_d = writedata;
        end
        if ((state_d == ARMED) && (timer_q == TIMER_LAST)) begin
          state_d = TIMEOUT;
        end
      end
      default: begin
        if (start) begin
          state_d     = ARMED;
          count_d     = (cfg_count > DEPTH_CNT) ? DEPTH_CNT : cfg_count;
          match_d     = '0;
          fail_adr_d  = '0;
          fail_data_d = '0;
          timer_d     = '0;
        end
      end
    endcase
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      match_q     <= '0;
      fail_adr_q  <= '0;
      fail_data_q <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      match_q     <= match_d;
      fail_adr_q  <= fail_adr_d;
      fail_data_q <= fail_data_d;
      timer_q     <= timer_d;
      busy_q      <= (state_d == ARMED);
      pass_q      <= (state_d == PASS);
      fail_q      <= (state_d == FAIL);
      timeout_q   <= (state_d == TIMEOUT);
    end
  end

  assign busy        = busy_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign match_count = match_q;
  assign fail_adr    = fail_adr_q;
  assign fail_data   = fail_data_q;

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter WIDTH, 16, data/address bus width in bits.
REQ-002 Parameter DEPTH, 4, number of expected-write entries; $clog2 widths use max(1, ...).
REQ-003 Parameter IGNORE_ADR, 80, address whose unexpected writes are tolerated (scratch).
REQ-004 Parameter TIMEOUT_CYCLES, 4096, armed-cycle budget before timeout.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cfg_we  in  1  write expected entry cfg_idx.
REQ-008 cfg_idx  in  $clog2(DEPTH)  expected-table index.
REQ-009 cfg_adr, cfg_data  in  WIDTH each  expected address/data for the entry.
REQ-010 cfg_count  in  $clog2(DEPTH+1)  number of expected writes, latched on start.
REQ-011 start  in  1  arm checker (one-cycle pulse).
REQ-012 memwrite  in  1  processor store strobe.
REQ-013 dataadr, writedata  in  WIDTH each  store address/data.
REQ-014 busy, pass, fail, timeout  out  1 each  status flags.
REQ-015 match_count  out  $clog2(DEPTH+1)  expected writes matched so far.
REQ-016 fail_adr, fail_data  out  WIDTH each  captured offending store.

Function
REQ-017 States IDLE, ARMED, PASS, FAIL, TIMEOUT; busy=1 only in ARMED; pass/fail/timeout=1 only in the same-named state.
REQ-018 cfg_we writes the table in IDLE, PASS, FAIL, TIMEOUT; ignored in ARMED; cfg_idx>=DEPTH ignored.
REQ-019 start in any non-ARMED state: -> ARMED next edge; latch count=min(cfg_count, DEPTH); clear match_count, fail_adr, fail_data, timer; start in ARMED ignored.
REQ-020 start with latched count 0: ARMED for exactly one cycle, then PASS.
REQ-021 In ARMED, a cycle with memwrite===1 is evaluated at that rising edge against entry ptr=match_count.
REQ-022 Match (dataadr==exp_adr[ptr] and writedata==exp_data[ptr]): match_count+1; if new value==count -> PASS.
REQ-023 Non-match with dataadr==IGNORE_ADR: no state change; match has priority over ignore.
REQ-024 Any other store: -> FAIL, capture dataadr/writedata into fail_adr/fail_data.
REQ-025 memwrite 0 or X/Z: no evaluation.
REQ-026 Timer counts ARMED cycles; ARMED and timer==TIMEOUT_CYCLES-1 with no terminal event that cycle -> TIMEOUT; PASS/FAIL in same cycle take priority.
REQ-027 Stores outside ARMED are ignored; PASS/FAIL/TIMEOUT are sticky until start or reset.
REQ-028 Outputs are registered; flags valid the cycle after the deciding edge.

Reset
REQ-029 reset=1 at a rising edge: state IDLE, all flags 0, match_count 0, fail_adr 0, fail_data 0, timer 0; count 0.
REQ-030 Reset mid-ARMED aborts the check with no flag asserted; expected table is not cleared; reset overrides start and cfg_we.

Verification
REQ-031 Table[0]=(84,7), count 1, start; stores (80,3),(80,5),(84,7) -> pass=1 after third store, fail=0, match_count=1.
REQ-032 Same config; store (88,7) -> fail=1 next cycle, fail_adr=88, fail_data=7, match_count=0.
REQ-033 Table (84,7),(88,9), count 2; stores (88,9) first -> fail, fail_adr=88; rerun in order -> pass, match_count=2.
REQ-034 TIMEOUT_CYCLES=16, count 1, no stores -> timeout=1 exactly 16 cycles after ARMED entry; matching store on cycle 16 -> pass instead.
REQ-035 Table[0]=(80,1); store (80,1) -> pass (match beats ignore); start with cfg_count=0 -> pass after one ARMED cycle.
REQ-036 Reset pulsed mid-ARMED after one match -> all outputs 0; start again reuses retained table and passes.
